// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu: iterative 32-bit multiply/divide unit with HI/LO result registers.
//
// Multiply uses shift-add and divide uses restoring division, one bit per
// cycle, so every operation takes exactly 32 cycles after it is accepted.
// Signed operations run on operand magnitudes and fix the signs at the end.
//
// Ports
//   clk    in   1   clock, rising edge
//   rst    in   1   synchronous active-high reset
//   start  in   1   begin an operation (only honoured in IDLE)
//   op     in   2   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   src_a  in  32   multiplicand / dividend; MTHI/MTLO data
//   src_b  in  32   multiplier / divisor
//   hi_we  in   1   MTHI strobe (IDLE only, start has priority)
//   lo_we  in   1   MTLO strobe (IDLE only, start has priority)
//   busy   out  1   operation in progress
//   done   out  1   one-cycle pulse when a new result first appears
//   hi     out 32   product upper word or remainder
//   lo     out 32   product lower word or quotient
// ---------------------------------------------------------------------------
module mdu (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hi_we,
    input  logic        lo_we,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic StIdle = 1'b0;
    localparam logic StRun  = 1'b1;

    logic        state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_lo_q, neg_lo_d;     // negate product / quotient
    logic        neg_hi_q, neg_hi_d;     // negate remainder
    logic        b_zero_q, b_zero_d;
    logic [31:0] a_raw_q, a_raw_d;       // original dividend, for divide-by-zero
    logic [31:0] b_mag_q, b_mag_d;       // addend (multiply) or divisor (divide)
    logic [63:0] acc_q, acc_d;           // {product} or {remainder, quotient}
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    // Operand magnitudes; op[0] selects the signed variants.
    logic [31:0] a_mag_in, b_mag_in;
    logic        a_neg_in, b_neg_in;

    always_comb begin
        a_neg_in = op[0] & src_a[31];
        b_neg_in = op[0] & src_b[31];
        a_mag_in = a_neg_in ? (~src_a + 32'd1) : src_a;
        b_mag_in = b_neg_in ? (~src_b + 32'd1) : src_b;
    end

    // One iteration of shift-add multiply: add the addend into the upper half
    // when the current multiplier bit is set, then shift right with carry.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_mag_q} : 33'd0);
        mul_next = {mul_sum, acc_q[31:1]};
    end

    // One iteration of restoring division on {rem, quot}: the shifted partial
    // remainder is acc_q[63:31]; subtract the divisor only if it fits. The
    // difference is below the divisor, so 32 bits of it are enough.
    logic        div_ge;
    logic [31:0] div_rem_sub;
    logic [63:0] div_next;

    always_comb begin
        div_ge      = acc_q[63:31] >= {1'b0, b_mag_q};
        div_rem_sub = acc_q[62:31] - b_mag_q;
        div_next    = div_ge ? {div_rem_sub, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
    end

    logic [63:0] acc_next;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix;
    logic [31:0] res_hi, res_lo;

    always_comb begin
        acc_next = is_div_q ? div_next : mul_next;
        prod_fix = neg_lo_q ? (~mul_next + 64'd1) : mul_next;
        quot_fix = neg_lo_q ? (~div_next[31:0] + 32'd1) : div_next[31:0];
        rem_fix  = neg_hi_q ? (~div_next[63:32] + 32'd1) : div_next[63:32];
        if (!is_div_q) begin
            res_hi = prod_fix[63:32];
            res_lo = prod_fix[31:0];
        end else if (b_zero_q) begin
            res_hi = a_raw_q;
            res_lo = 32'hFFFF_FFFF;
        end else begin
            res_hi = rem_fix;
            res_lo = quot_fix;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        b_zero_d = b_zero_q;
        a_raw_d  = a_raw_q;
        b_mag_d  = b_mag_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        if (state_q == StIdle) begin
            if (start) begin
                // Start wins over MTHI/MTLO; the strobes are dropped.
                state_d  = StRun;
                cnt_d    = 5'd0;
                is_div_d = op[1];
                neg_lo_d = a_neg_in ^ b_neg_in;
                neg_hi_d = a_neg_in;
                b_zero_d = (src_b == 32'd0);
                a_raw_d  = src_a;
                b_mag_d  = b_mag_in;
                acc_d    = {32'd0, a_mag_in};
            end else begin
                if (hi_we) hi_d = src_a;
                if (lo_we) lo_d = src_a;
            end
        end else begin
            acc_d = acc_next;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                // Iteration 32: publish the result, leave RUN.
                hi_d    = res_hi;
                lo_d    = res_lo;
                done_d  = 1'b1;
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 5'd0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            b_zero_q <= 1'b0;
            a_raw_q  <= 32'd0;
            b_mag_q  <= 32'd0;
            acc_q    <= 64'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            b_zero_q <= b_zero_d;
            a_raw_q  <= a_raw_d;
            b_mag_q  <= b_mag_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// ---------------------------------------------------------------------------
// tb_mdu: scoreboard bench for mdu. Stimulus pushes the reference result for
// every accepted operation; a negedge monitor pops and compares on done.
// ---------------------------------------------------------------------------
module tb_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hi_we;
    logic        lo_we;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];

    // Architectural HI/LO as the bench believes them to be.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definitions.
    function automatic void model(input logic [1:0] o, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] rh, output logic [31:0] rl);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        logic [63:0] tq, tr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rh = 32'd0;
        rl = 32'd0;
        case (o)
            2'b00: begin
                p  = {32'd0, a} * {32'd0, b};
                rh = p[63:32];
                rl = p[31:0];
            end
            2'b01: begin
                p  = 64'(sa * sb);
                rh = p[63:32];
                rl = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    rl = 32'hFFFF_FFFF;
                    rh = a;
                end else if (o == 2'b10) begin
                    rl = a / b;
                    rh = a % b;
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    tq = 64'(sq);
                    tr = 64'(sr);
                    rl = tq[31:0];
                    rh = tr[31:0];
                end
            end
        endcase
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            check32("done_while_busy", {31'd0, busy}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no result pending");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check32("result_hi", hi, e.hi);
                check32("result_lo", lo, e.lo);
            end
        end
    end

    // Caller is just after a negedge. Returns just after the negedge in which
    // done is visible, so back-to-back calls start in the done cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit interfere);
        logic [31:0] eh, el, ph, pl;
        int          n;
        bit          hold_ok;
        exp_t        e;
        model(o, a, b, eh, el);
        e.hi = eh;
        e.lo = el;
        exp_q.push_back(e);
        ph = m_hi;
        pl = m_lo;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        hi_we = interfere;
        lo_we = interfere;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        op    = 2'($urandom);
        n       = 0;
        hold_ok = 1'b1;
        while (n <= 100) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (hi !== ph || lo !== pl) hold_ok = 1'b0;
            if (interfere) begin
                start = 1'($urandom);
                hi_we = 1'($urandom);
                lo_we = 1'($urandom);
                src_a = $urandom;
                src_b = $urandom;
                op    = 2'($urandom);
            end
        end
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check32("busy_cycles", 32'(n), 32'd32);
        check32("hold_during_run", {31'd0, hold_ok}, 32'd1);
        check32("done_at_end", {31'd0, done}, 32'd1);
        m_hi = eh;
        m_lo = el;
    endtask

    // MTHI / MTLO in IDLE.
    task automatic mt(input bit hw, input bit lw, input logic [31:0] val);
        hi_we = hw;
        lo_we = lw;
        src_a = val;
        start = 1'b0;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        @(negedge clk);
        if (hw) m_hi = val;
        if (lw) m_lo = val;
        check32("mt_hi", hi, m_hi);
        check32("mt_lo", lo, m_lo);
        check32("mt_no_done", {31'd0, done}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        int unsigned k;
        k = $urandom_range(0, 9);
        case (k)
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        src_a = 32'd0;
        src_b = 32'd0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        repeat (3) @(negedge clk);
        check32("reset_hi", hi, 32'd0);
        check32("reset_lo", lo, 32'd0);
        check32("reset_busy", {31'd0, busy}, 32'd0);
        check32("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        mt(1'b1, 1'b0, 32'h1234_5678);
        mt(1'b0, 1'b1, 32'hCAFE_F00D);
        mt(1'b1, 1'b1, 32'h0BAD_BEEF);

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(2'b10, 32'd100, 32'd7, 1'b1);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'b11, 32'd7, 32'hFFFF_FFFE, 1'b1);
        run_op(2'b11, 32'd5, 32'd0, 1'b0);
        run_op(2'b10, 32'hDEAD_BEEF, 32'd0, 1'b0);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                mt(1'($urandom), 1'($urandom), $urandom);
            end
            run_op(2'($urandom), pick(), pick(), 1'($urandom));
        end

        // Abort a DIVU with rst in cycle 10 of RUN, colliding with start/hi_we.
        start = 1'b1;
        op    = 2'b10;
        src_a = 32'd1000;
        src_b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        hi_we = 1'b1;
        lo_we = 1'b1;
        src_a = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        @(negedge clk);
        check32("abort_busy", {31'd0, busy}, 32'd0);
        check32("abort_hi", hi, 32'd0);
        check32("abort_lo", lo, 32'd0);
        check32("abort_done", {31'd0, done}, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        // Any done in this window finds an empty queue and is flagged.
        repeat (40) @(negedge clk);
        run_op(2'b10, 32'd1000, 32'd3, 1'b0);

        repeat (3) @(negedge clk);
        check32("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL have no parameters; the operand width SHALL be fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state changes SHALL occur on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 start  in  1  request to begin an operation; sampled only in IDLE.
REQ-005 op  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 src_a  in  32  operand A (multiplicand or dividend), driven by register-file read port 1.
REQ-007 src_b  in  32  operand B (multiplier or divisor), driven by register-file read port 2.
REQ-008 hi_we  in  1  MTHI strobe: loads src_a into hi.
REQ-009 lo_we  in  1  MTLO strobe: loads src_a into lo.
REQ-010 busy  out  1  operation in progress.
REQ-011 done  out  1  one-cycle pulse marking the cycle in which a new result is first visible.
REQ-012 hi  out  32  HI register: product upper word, or remainder.
REQ-013 lo  out  32  LO register: product lower word, or quotient.

Function
REQ-014 FSM states SHALL be IDLE and RUN.
- IDLE->RUN on start=1.
- RUN->IDLE after iteration 32.
- No other transitions except reset.
REQ-015 If start=1 at edge N in IDLE, the block SHALL latch op, src_a and src_b at edge N and assert busy from edge N until edge N+32.
REQ-016 At edge N+32 the block SHALL:
- write hi and lo;
- deassert busy;
- assert done for exactly one cycle, cleared at edge N+33.
Latency is 32 cycles for every op.
REQ-017 Operand changes on src_a/src_b/op while busy SHALL NOT affect the result.
REQ-018 start while busy SHALL be ignored and SHALL NOT queue.
REQ-019 hi_we/lo_we while busy SHALL be ignored.
REQ-020 In IDLE without start:
- hi_we=1 SHALL load hi<=src_a at the edge.
- lo_we=1 SHALL load lo<=src_a at the edge.
- Both strobes together SHALL load both registers.
REQ-021 start and hi_we/lo_we together in IDLE: start SHALL win and the strobes SHALL be discarded.
REQ-022 hi and lo SHALL hold their value throughout RUN; no partial results SHALL be visible.
REQ-023 Multiply ({hi,lo} = 64-bit product):
- MULTU: unsigned, computed by iterative shift-add, one bit per cycle.
- MULT: multiply operand magnitudes, then negate the 64-bit result if the operand signs differ.
REQ-024 Divide (lo = quotient, hi = remainder):
- DIVU: restoring division, one quotient bit per cycle.
- DIV: quotient truncates toward zero; the remainder takes the sign of the dividend.
REQ-025 Divisor zero (DIVU or DIV): lo SHALL be 0xFFFFFFFF and hi SHALL be the dividend; latency is unchanged and no exception is raised.
REQ-026 DIV of 0x80000000 by 0xFFFFFFFF: lo SHALL be 0x80000000 and hi SHALL be 0x00000000.
REQ-027 done SHALL never be asserted while busy=1.
REQ-028 done SHALL never be asserted for an MTHI or MTLO write.
REQ-029 A new start SHALL be accepted in the done cycle (the block is in IDLE).

Reset
REQ-030 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, hi=0x00000000, lo=0x00000000 and clear the internal iteration counter.
REQ-031 rst SHALL override start, hi_we and lo_we in the same cycle.
REQ-032 rst during RUN SHALL abort the operation; no result SHALL be written and no done pulse SHALL follow.
REQ-033 After rst is released, the first start SHALL complete with normal 32-cycle latency.

Verification
REQ-034 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy high 32 cycles; then hi=0xFFFFFFFE, lo=0x00000001; done high exactly 1 cycle.
REQ-035 MULT 0xFFFFFFFD (-3) x 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-036 DIVU 100/7 -> lo=14, hi=2; DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 7 / 0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
REQ-037 DIV 5/0 -> lo=0xFFFFFFFF, hi=5; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-038 hi_we with src_a=0x12345678 in IDLE -> hi=0x12345678 next cycle; hi_we and a second start during RUN -> both ignored, first result intact, busy falls at N+32.
REQ-039 Start DIVU, assert rst at cycle 10 of RUN -> busy=0, hi=lo=0, no done pulse; a subsequent start completes in 32 cycles with the correct result.
